ib_endpoint_wr_unpacker: RTL and testbench



---
 rtl/ib_endpoint_wr_unpacker.sv | 215 +++++++++++++++++++++
 tb/tb_ib_endpoint_wr_unpacker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_endpoint_wr_unpacker.sv
// IB write endpoint: assembles the 64-bit header from DATA_WIDTH link words and streams payload to a user write port.
// Optional address window check enabled by defining IB_EP_ADDR_CHECK_EN (uses BASE_ADDR/LIMIT_ADDR).
//
// state   | meaning
// ST_HDR  | ready; collecting header words, pre-SOP words discarded
// ST_DATA | payload pass-through to the user port, back-pressured by WR_RDY
// ST_DROP | ready; swallowing the rest of a rejected packet up to EOP
module ib_endpoint_wr_unpacker #(
   parameter int          DATA_WIDTH = 64,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] LIMIT_ADDR = 32'hFFFF_FFFF
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic [DATA_WIDTH-1:0]   IB_DOWN_DATA,
   input  logic                    IB_DOWN_SOP_N,
   input  logic                    IB_DOWN_EOP_N,
   input  logic                    IB_DOWN_SRC_RDY_N,
   output logic                    IB_DOWN_DST_RDY_N,
   output logic [31:0]             WR_ADDR,
   output logic [DATA_WIDTH-1:0]   WR_DATA,
   output logic [DATA_WIDTH/8-1:0] WR_BE,
   output logic                    WR_REQ,
   input  logic                    WR_RDY,
   output logic [11:0]             WR_LENGTH,
   output logic                    WR_SOF,
   output logic                    WR_EOF,
   output logic                    ERR_DROP,
   output logic                    ERR_LEN
);

   localparam int HDR_WORDS = 64 / DATA_WIDTH;
   localparam int BW        = DATA_WIDTH / 8;
   localparam int K         = $clog2(BW);
   localparam int AW        = 32 - K;

   typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_DROP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  hdr_cnt_q, hdr_cnt_d;
   logic [63:0] hdr_buf_q, hdr_buf_d;
   logic [31:0] addr_q, addr_d;
   logic [11:0] len_q, len_d;
   logic [12:0] nwords_q, nwords_d;
   logic [12:0] word_cnt_q, word_cnt_d;
   logic        err_drop_q, err_drop_d;
   logic        err_len_q, err_len_d;
   logic        live_q, live_d;

   logic          dst_rdy_n;
   logic          xfer;
   logic          sop, eop;
   logic [1:0]    hdr_idx;
   logic          hdr_take, hdr_last;
   logic [63:0]   hdr_full;
   logic [11:0]   hdr_len;
   logic [3:0]    hdr_type;
   logic [31:0]   hdr_addr;
   logic [12:0]   hdr_len13;
   logic [12:0]   hdr_nwords;
   logic          range_ok, pkt_ok;
   logic          word_last;
   logic [K-1:0]  lane_end;
   logic [BW-1:0] first_mask, last_mask;
   logic [15:0]   unused_tag;

   assign sop  = !IB_DOWN_SOP_N;
   assign eop  = !IB_DOWN_EOP_N;
   assign xfer = !IB_DOWN_SRC_RDY_N && !dst_rdy_n;

   // Header word slots fill least-significant first; a SOP always lands in slot 0.
   assign hdr_idx  = sop ? 2'd0 : hdr_cnt_q;
   assign hdr_take = xfer && (state_q == ST_HDR) && (sop || hdr_cnt_q != 2'd0);
   assign hdr_last = hdr_take && (hdr_idx == 2'(HDR_WORDS - 1));

   always_comb begin
      hdr_full = hdr_buf_q;
      for (int i = 0; i < HDR_WORDS; i++) begin
         if (hdr_idx == 2'(i)) hdr_full[i*DATA_WIDTH +: DATA_WIDTH] = IB_DOWN_DATA;
      end
   end

   assign hdr_len    = hdr_full[11:0];
   assign hdr_type   = hdr_full[15:12];
   assign hdr_addr   = hdr_full[47:16];
   assign unused_tag = hdr_full[63:48];
   assign hdr_len13  = {(hdr_len == 12'd0), hdr_len};
   assign hdr_nwords = ((13'(hdr_addr[K-1:0]) + hdr_len13 - 13'd1) >> K) + 13'd1;

`ifdef IB_EP_ADDR_CHECK_EN
   assign range_ok = ({1'b0, hdr_addr} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, hdr_addr} + {20'd0, hdr_len13} - 33'd1 <= {1'b0, LIMIT_ADDR});
`else
   logic [63:0] unused_range;
   assign unused_range = {BASE_ADDR, LIMIT_ADDR};
   assign range_ok     = 1'b1;
`endif

   assign pkt_ok = (hdr_type == 4'h1) && range_ok;

   // 4096-byte packets have zero low length bits, so len_q's low bits give the end lane directly.
   assign word_last  = (word_cnt_q == nwords_q - 13'd1);
   assign lane_end   = addr_q[K-1:0] + len_q[K-1:0] - K'(1);
   assign first_mask = {BW{1'b1}} << addr_q[K-1:0];
   assign last_mask  = {BW{1'b1}} >> (K'(BW - 1) - lane_end);

   always_comb begin
      dst_rdy_n = 1'b1;
      WR_REQ    = 1'b0;
      WR_ADDR   = '0;
      WR_DATA   = '0;
      WR_BE     = '0;
      WR_SOF    = 1'b0;
      WR_EOF    = 1'b0;
      if (live_q) begin
         dst_rdy_n = 1'b0;
         if (state_q == ST_DATA) begin
            dst_rdy_n = !WR_RDY;
            WR_REQ    = !IB_DOWN_SRC_RDY_N;
            WR_ADDR   = {addr_q[31:K] + AW'(word_cnt_q), {K{1'b0}}};
            WR_DATA   = IB_DOWN_DATA;
            WR_SOF    = (word_cnt_q == 13'd0);
            WR_EOF    = word_last;
            WR_BE     = {BW{1'b1}};
            if (word_cnt_q == 13'd0) WR_BE = WR_BE & first_mask;
            if (word_last)           WR_BE = WR_BE & last_mask;
         end
      end
   end

   assign IB_DOWN_DST_RDY_N = dst_rdy_n;
   assign WR_LENGTH         = len_q;
   assign ERR_DROP          = err_drop_q;
   assign ERR_LEN           = err_len_q;

   always_comb begin
      state_d    = state_q;
      hdr_cnt_d  = hdr_cnt_q;
      hdr_buf_d  = hdr_buf_q;
      addr_d     = addr_q;
      len_d      = len_q;
      nwords_d   = nwords_q;
      word_cnt_d = word_cnt_q;
      err_drop_d = 1'b0;
      err_len_d  = 1'b0;
      live_d     = 1'b1;
      case (state_q)
         ST_HDR: begin
            if (hdr_take) begin
               hdr_buf_d = hdr_full;
               hdr_cnt_d = hdr_last ? 2'd0 : hdr_idx + 2'd1;
               if (hdr_last) begin
                  err_drop_d = !pkt_ok;
                  if (eop) begin
                     err_len_d = 1'b1;
                  end else if (pkt_ok) begin
                     addr_d     = hdr_addr;
                     len_d      = hdr_len;
                     nwords_d   = hdr_nwords;
                     word_cnt_d = 13'd0;
                     state_d    = ST_DATA;
                  end else begin
                     state_d = ST_DROP;
                  end
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               word_cnt_d = word_cnt_q + 13'd1;
               if (eop) begin
                  err_len_d  = !word_last;
                  word_cnt_d = 13'd0;
                  state_d    = ST_HDR;
               end else if (word_last) begin
                  err_len_d  = 1'b1;
                  word_cnt_d = 13'd0;
                  state_d    = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (xfer && eop) state_d = ST_HDR;
         end
         default: state_d = ST_HDR;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_HDR;
         hdr_cnt_q  <= '0;
         hdr_buf_q  <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         nwords_q   <= '0;
         word_cnt_q <= '0;
         err_drop_q <= 1'b0;
         err_len_q  <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_cnt_q  <= hdr_cnt_d;
         hdr_buf_q  <= hdr_buf_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         nwords_q   <= nwords_d;
         word_cnt_q <= word_cnt_d;
         err_drop_q <= err_drop_d;
         err_len_q  <= err_len_d;
         live_q     <= live_d;
      end
   end

endmodule

// File: tb/tb_ib_endpoint_wr_unpacker.sv
// Directed bench for ib_endpoint_wr_unpacker: a 64-bit instance and a 16-bit instance share clock and reset.
module tb_ib_endpoint_wr_unpacker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [63:0] d64;  logic sop64_n, eop64_n, src64_n, dst64_n;
   logic [31:0] a64;  logic [63:0] wd64; logic [7:0] be64;
   logic req64, rdy64, sof64, eof64, edrop64, elen64;
   logic [11:0] len64;

   logic [15:0] d16;  logic sop16_n, eop16_n, src16_n, dst16_n;
   logic [31:0] a16;  logic [15:0] wd16; logic [1:0] be16;
   logic req16, rdy16, sof16, eof16, edrop16, elen16;
   logic [11:0] len16;

   ib_endpoint_wr_unpacker #(.DATA_WIDTH(64), .BASE_ADDR(32'h0000_1000), .LIMIT_ADDR(32'hFFFF_FFFF)) u_dut64 (
      .CLK(clk), .RESET_N(rst_n), .IB_DOWN_DATA(d64), .IB_DOWN_SOP_N(sop64_n), .IB_DOWN_EOP_N(eop64_n),
      .IB_DOWN_SRC_RDY_N(src64_n), .IB_DOWN_DST_RDY_N(dst64_n), .WR_ADDR(a64), .WR_DATA(wd64), .WR_BE(be64),
      .WR_REQ(req64), .WR_RDY(rdy64), .WR_LENGTH(len64), .WR_SOF(sof64), .WR_EOF(eof64),
      .ERR_DROP(edrop64), .ERR_LEN(elen64));

   ib_endpoint_wr_unpacker #(.DATA_WIDTH(16)) u_dut16 (
      .CLK(clk), .RESET_N(rst_n), .IB_DOWN_DATA(d16), .IB_DOWN_SOP_N(sop16_n), .IB_DOWN_EOP_N(eop16_n),
      .IB_DOWN_SRC_RDY_N(src16_n), .IB_DOWN_DST_RDY_N(dst16_n), .WR_ADDR(a16), .WR_DATA(wd16), .WR_BE(be16),
      .WR_REQ(req16), .WR_RDY(rdy16), .WR_LENGTH(len16), .WR_SOF(sof16), .WR_EOF(eof16),
      .ERR_DROP(edrop16), .ERR_LEN(elen16));

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
      logic        sof;
      logic        eof;
   } wr_t;

   wr_t q64[$];
   wr_t q16[$];
   int  n_drop64 = 0, n_len64 = 0, n_drop16 = 0, n_len16 = 0, n_mirror_bad = 0;
   int  n_tests = 0, n_fail = 0;
   bit  tog_en = 1'b0;

   // Observe accepted user writes and error pulses away from the active edge.
   always @(negedge clk) begin
      if (req64 && rdy64) q64.push_back('{a64, wd64, be64, sof64, eof64});
      if (req16 && rdy16) q16.push_back('{a16, {48'd0, wd16}, {6'd0, be16}, sof16, eof16});
      if (edrop64) n_drop64++;
      if (elen64)  n_len64++;
      if (edrop16) n_drop16++;
      if (elen16)  n_len16++;
      if (req64 && (dst64_n != !rdy64)) n_mirror_bad++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] hdr(input logic [3:0] typ, input logic [31:0] addr, input logic [11:0] len);
      return {16'hA5A5, addr, typ, len};
   endfunction

   // Present one word and hold it until the endpoint takes it; returns at posedge+1.
   task automatic put(input bit w16, input logic [63:0] d, input bit sop, input bit eop);
      bit ok;
      int n;
      n = 0;
      if (w16) begin
         d16 = d[15:0]; sop16_n = !sop; eop16_n = !eop; src16_n = 1'b0;
      end else begin
         d64 = d; sop64_n = !sop; eop64_n = !eop; src64_n = 1'b0;
      end
      do begin
         @(negedge clk);
         ok = w16 ? !dst16_n : !dst64_n;
         @(posedge clk);
         #1;
         if (tog_en) rdy64 = !rdy64;
         n++;
      end while (!ok && n < 4000);
      if (!ok) chk("put_ack", {63'd0, ok}, 64'd1);
   endtask

   task automatic send_hdr(input bit w16, input logic [63:0] h, input bit eop);
      logic [63:0] s;
      if (!w16) begin
         put(1'b0, h, 1'b1, eop);
      end else begin
         for (int i = 0; i < 4; i++) begin
            s = h >> (16 * i);
            put(1'b1, {48'd0, s[15:0]}, i == 0, eop && (i == 3));
         end
      end
   endtask

   task automatic idle(input int n);
      src64_n = 1'b1; sop64_n = 1'b1; eop64_n = 1'b1;
      src16_n = 1'b1; sop16_n = 1'b1; eop16_n = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int base, bd, bl, errs;
   logic [7:0] exp_be;

   initial begin
      rst_n = 1'b0;
      d64 = '0; d16 = '0; rdy64 = 1'b1; rdy16 = 1'b1;
      idle(3);
      @(negedge clk);
      chk("rst_dst_rdy_n", {63'd0, dst64_n}, 64'd1);
      chk("rst_wr_req", {63'd0, req64}, 64'd0);
      chk("rst_wr_addr", {32'd0, a64}, 64'd0);
      chk("rst_wr_length", {52'd0, len64}, 64'd0);
      chk("rst_errs", {62'd0, edrop64, elen64}, 64'd0);
      chk("rst_dst_rdy_n16", {63'd0, dst16_n}, 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      @(negedge clk);
      chk("hdr_ready", {63'd0, dst64_n}, 64'd0);
      @(posedge clk); #1;

      // Unaligned two-word write.
      base = q64.size(); bd = n_drop64; bl = n_len64;
      send_hdr(1'b0, hdr(4'h1, 32'h1003, 12'd6), 1'b0);
      put(1'b0, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
      put(1'b0, 64'h5555_6666_7777_8888, 1'b0, 1'b1);
      idle(2);
      chk("t1_nwr", 64'(q64.size() - base), 64'd2);
      chk("t1_a0", {32'd0, q64[base].addr}, 64'h1000);
      chk("t1_be0", {56'd0, q64[base].be}, 64'hF8);
      chk("t1_sof0", {62'd0, q64[base].sof, q64[base].eof}, 64'd2);
      chk("t1_d0", q64[base].data, 64'h1111_2222_3333_4444);
      chk("t1_a1", {32'd0, q64[base+1].addr}, 64'h1008);
      chk("t1_be1", {56'd0, q64[base+1].be}, 64'h01);
      chk("t1_eof1", {62'd0, q64[base+1].sof, q64[base+1].eof}, 64'd1);
      chk("t1_len", {52'd0, len64}, 64'd6);
      chk("t1_errs", 64'((n_drop64 - bd) + (n_len64 - bl)), 64'd0);

`ifndef IB_EP_ADDR_CHECK_EN
      // 4096-byte write with WR_RDY toggling every cycle.
      base = q64.size(); bl = n_len64;
      send_hdr(1'b0, hdr(4'h1, 32'h0, 12'd0), 1'b0);
      tog_en = 1'b1;
      for (int i = 0; i < 512; i++) put(1'b0, 64'(i) ^ 64'hC0DE_0000_0000_0000, 1'b0, i == 511);
      tog_en = 1'b0; rdy64 = 1'b1;
      idle(2);
      chk("t2_nwr", 64'(q64.size() - base), 64'd512);
      errs = 0;
      for (int i = 0; i < 512; i++) begin
         if (q64[base+i].addr !== 32'(i * 8) || q64[base+i].be !== 8'hFF ||
             q64[base+i].data !== (64'(i) ^ 64'hC0DE_0000_0000_0000)) errs++;
      end
      chk("t2_words", 64'(errs), 64'd0);
      chk("t2_sof_eof", {60'd0, q64[base].sof, q64[base].eof, q64[base+511].sof, q64[base+511].eof}, 64'b1001);
      chk("t2_dst_mirror", 64'(n_mirror_bad), 64'd0);
      chk("t2_len_err", 64'(n_len64 - bl), 64'd0);
`else
      // Address below BASE_ADDR is rejected.
      base = q64.size(); bd = n_drop64;
      send_hdr(1'b0, hdr(4'h1, 32'h0FFC, 12'd4), 1'b0);
      put(1'b0, 64'h1, 1'b0, 1'b1);
      idle(2);
      chk("tc_drop", 64'(n_drop64 - bd), 64'd1);
      chk("tc_nwr", 64'(q64.size() - base), 64'd0);
`endif

      // 16-bit link, four header words, single odd-byte write.
      base = q16.size(); bl = n_len16;
      send_hdr(1'b1, hdr(4'h1, 32'h21, 12'd1), 1'b0);
      put(1'b1, 64'hBEEF, 1'b0, 1'b1);
      idle(2);
      chk("t3_nwr", 64'(q16.size() - base), 64'd1);
      chk("t3_addr", {32'd0, q16[base].addr}, 64'h20);
      chk("t3_be", {56'd0, q16[base].be}, 64'h2);
      chk("t3_sof_eof", {62'd0, q16[base].sof, q16[base].eof}, 64'd3);
      chk("t3_data", q16[base].data, 64'hBEEF);
      chk("t3_len", {52'd0, len16}, 64'd1);
      chk("t3_len_err", 64'(n_len16 - bl), 64'd0);

      // Non-write type is swallowed, next write proceeds.
      base = q64.size(); bd = n_drop64; bl = n_len64;
      send_hdr(1'b0, hdr(4'h2, 32'h7000, 12'd24), 1'b0);
      for (int i = 0; i < 3; i++) put(1'b0, 64'(i), 1'b0, i == 2);
      idle(2);
      chk("t4_drop", 64'(n_drop64 - bd), 64'd1);
      chk("t4_nwr", 64'(q64.size() - base), 64'd0);
      chk("t4_len_err", 64'(n_len64 - bl), 64'd0);
      send_hdr(1'b0, hdr(4'h1, 32'h2000, 12'd16), 1'b0);
      put(1'b0, 64'hAAAA, 1'b0, 1'b0);
      put(1'b0, 64'hBBBB, 1'b0, 1'b1);
      idle(2);
      chk("t4_nwr2", 64'(q64.size() - base), 64'd2);
      chk("t4_a1", {32'd0, q64[base+1].addr}, 64'h2008);
      exp_be = 8'hFF;
      chk("t4_be", {48'd0, q64[base].be, q64[base+1].be}, {48'd0, exp_be, exp_be});
      chk("t4_eof1", {62'd0, q64[base+1].sof, q64[base+1].eof}, 64'd1);

      // EOP on the first data word of a 16-byte write.
      base = q64.size(); bl = n_len64;
      send_hdr(1'b0, hdr(4'h1, 32'h3000, 12'd16), 1'b0);
      put(1'b0, 64'hCCCC, 1'b0, 1'b1);
      rdy64 = 1'b0;
      idle(0);
      @(negedge clk);
      chk("t5_hdr_next", {62'd0, dst64_n, req64}, 64'd0);
      @(posedge clk); #1;
      idle(2);
      rdy64 = 1'b1;
      chk("t5_nwr", 64'(q64.size() - base), 64'd1);
      chk("t5_eof0", {62'd0, q64[base].sof, q64[base].eof}, 64'd2);
      chk("t5_len_err", 64'(n_len64 - bl), 64'd1);

      // Length reaches its last word without EOP; extra word dropped.
      base = q64.size(); bd = n_drop64; bl = n_len64;
      send_hdr(1'b0, hdr(4'h1, 32'h6000, 12'd8), 1'b0);
      put(1'b0, 64'hD0, 1'b0, 1'b0);
      put(1'b0, 64'hD1, 1'b0, 1'b1);
      idle(2);
      chk("t6_nwr", 64'(q64.size() - base), 64'd1);
      chk("t6_eof", {62'd0, q64[base].sof, q64[base].eof}, 64'd3);
      chk("t6_errs", {32'(n_drop64 - bd), 32'(n_len64 - bl)}, {32'd0, 32'd1});

      // EOP on the header word itself.
      base = q64.size(); bl = n_len64;
      send_hdr(1'b0, hdr(4'h1, 32'h6100, 12'd8), 1'b1);
      idle(2);
      chk("t7_nwr", 64'(q64.size() - base), 64'd0);
      chk("t7_len_err", 64'(n_len64 - bl), 64'd1);

      // Reset during the data phase; leftover words are pre-SOP garbage.
      base = q64.size(); bd = n_drop64; bl = n_len64;
      send_hdr(1'b0, hdr(4'h1, 32'h4000, 12'd32), 1'b0);
      put(1'b0, 64'hE0, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t8_rst_dst", {63'd0, dst64_n}, 64'd1);
      chk("t8_rst_req_addr", {31'd0, req64, a64}, 64'd0);
      chk("t8_rst_len", {52'd0, len64}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      put(1'b0, hdr(4'h1, 32'h4000, 12'd8), 1'b0, 1'b0);
      put(1'b0, 64'hE2, 1'b0, 1'b0);
      put(1'b0, 64'hE3, 1'b0, 1'b1);
      idle(2);
      chk("t8_nwr", 64'(q64.size() - base), 64'd1);
      chk("t8_errs", 64'((n_drop64 - bd) + (n_len64 - bl)), 64'd0);
      send_hdr(1'b0, hdr(4'h1, 32'h5004, 12'd4), 1'b0);
      put(1'b0, 64'hF00D, 1'b0, 1'b1);
      idle(2);
      chk("t8_nwr2", 64'(q64.size() - base), 64'd2);
      chk("t8_addr", {32'd0, q64[base+1].addr}, 64'h5000);
      chk("t8_be", {56'd0, q64[base+1].be}, 64'hF0);
      chk("t8_sof_eof", {62'd0, q64[base+1].sof, q64[base+1].eof}, 64'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
